// File: rtl/dino_sfx_gen_if.sv
// Event/sample bus between the game logic and the Dino Run sound-effect generator.
// The master drives strobes and triggers; the slave returns the sample stream and status.
interface dino_sfx_gen_if;
    logic               sample_en;
    logic               trig_jump;
    logic               trig_score;
    logic               trig_over;
    logic               mute;
    logic signed [15:0] audio_data;
    logic               busy;
    logic [1:0]         sfx_id;

    modport master (
        output sample_en, trig_jump, trig_score, trig_over, mute,
        input  audio_data, busy, sfx_id
    );

    modport slave (
        input  sample_en, trig_jump, trig_score, trig_over, mute,
        output audio_data, busy, sfx_id
    );
endinterface

// File: rtl/dino_sfx_gen.sv
// Square-wave sound-effect generator: turns jump/score/game-over pulses into a signed
// 16-bit sample stream, one sample per sample_en, with game over > score > jump priority.
module dino_sfx_gen #(
    parameter logic signed [15:0] AMPLITUDE  = 16'sd8192,
    parameter int unsigned        MS_SAMPLES = 48
) (
    input logic           clk,
    input logic           reset,
    dino_sfx_gen_if.slave bus
);
    localparam int unsigned DurMax = 300 * MS_SAMPLES;
    localparam int unsigned DurW   = ($clog2(DurMax) > 16) ? $clog2(DurMax) : 16;

    typedef enum logic {StIdle, StPlay} state_t;

    state_t             r_state;
    logic [1:0]         r_sfx_id;
    logic               r_busy;
    logic [1:0]         r_note;
    logic [6:0]         r_half_cnt;
    logic [DurW-1:0]    r_dur_cnt;
    logic               r_phase;
    logic signed [15:0] r_audio;

    logic [1:0]         w_req;
    logic               w_accept;
    logic [6:0]         w_hp;
    int unsigned        w_ms;
    logic               w_last;
    logic [6:0]         w_hp_end;
    logic [DurW-1:0]    w_dur_end;

    always_comb begin
        w_req = 2'd0;
        if (bus.trig_over) begin
            w_req = 2'd3;
        end else if (bus.trig_score) begin
            w_req = 2'd2;
        end else if (bus.trig_jump) begin
            w_req = 2'd1;
        end
    end

    // Equal priority is accepted so a repeated trigger restarts its own effect.
    assign w_accept = (w_req != 2'd0) && ((r_state == StIdle) || (w_req >= r_sfx_id));

    always_comb begin
        w_hp   = 7'd24;
        w_ms   = 100;
        w_last = 1'b1;
        case ({r_sfx_id, r_note})
            {2'd2, 2'd0}: begin w_hp = 7'd18; w_ms = 60;  w_last = 1'b0; end
            {2'd2, 2'd1}: begin w_hp = 7'd12; w_ms = 60;  w_last = 1'b1; end
            {2'd3, 2'd0}: begin w_hp = 7'd32; w_ms = 150; w_last = 1'b0; end
            {2'd3, 2'd1}: begin w_hp = 7'd48; w_ms = 150; w_last = 1'b0; end
            {2'd3, 2'd2}: begin w_hp = 7'd64; w_ms = 300; w_last = 1'b1; end
            default:      begin w_hp = 7'd24; w_ms = 100; w_last = 1'b1; end
        endcase
    end

    assign w_hp_end  = w_hp - 7'd1;
    assign w_dur_end = DurW'(w_ms * MS_SAMPLES - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_sfx_id   <= 2'd0;
            r_busy     <= 1'b0;
            r_note     <= 2'd0;
            r_half_cnt <= 7'd0;
            r_dur_cnt  <= '0;
            r_phase    <= 1'b1;
            r_audio    <= 16'sd0;
        end else if (w_accept) begin
            // A load takes precedence over a coincident strobe; audio holds its value.
            r_state    <= StPlay;
            r_sfx_id   <= w_req;
            r_busy     <= 1'b1;
            r_note     <= 2'd0;
            r_half_cnt <= 7'd0;
            r_dur_cnt  <= '0;
            r_phase    <= 1'b1;
        end else if (bus.sample_en) begin
            if (r_state == StPlay) begin
                r_audio <= bus.mute ? 16'sd0 : (r_phase ? AMPLITUDE : -AMPLITUDE);
                if (r_dur_cnt == w_dur_end) begin
                    r_half_cnt <= 7'd0;
                    r_dur_cnt  <= '0;
                    r_phase    <= 1'b1;
                    if (w_last) begin
                        r_state  <= StIdle;
                        r_busy   <= 1'b0;
                        r_sfx_id <= 2'd0;
                        r_note   <= 2'd0;
                    end else begin
                        r_note <= r_note + 2'd1;
                    end
                end else begin
                    r_dur_cnt <= r_dur_cnt + 1'b1;
                    if (r_half_cnt == w_hp_end) begin
                        r_half_cnt <= 7'd0;
                        r_phase    <= ~r_phase;
                    end else begin
                        r_half_cnt <= r_half_cnt + 7'd1;
                    end
                end
            end else begin
                r_audio <= 16'sd0;
            end
        end
    end

    assign bus.audio_data = r_audio;
    assign bus.busy       = r_busy;
    assign bus.sfx_id     = r_sfx_id;
endmodule

// File: tb/tb_dino_sfx_gen.sv
// Directed bench for dino_sfx_gen with MS_SAMPLES = 1, AMPLITUDE = 8192 and a strobe every 4 clk.
// Expected samples come from the effect note tables written out below.
module tb_dino_sfx_gen;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    dino_sfx_gen_if sfx_bus ();

    dino_sfx_gen #(
        .AMPLITUDE  (16'sd8192),
        .MS_SAMPLES (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sfx_bus)
    );

    always #5 clk = ~clk;

    // Expected n-th sample (1-based) of effect fx from hand-written half-period/duration tables.
    function automatic logic signed [15:0] exp_wave(input int fx, input int n);
        int hp [3];
        int dur [3];
        int cnt;
        int idx;
        hp  = '{24, 0, 0};
        dur = '{100, 0, 0};
        cnt = 1;
        if (fx == 2) begin
            hp  = '{18, 12, 0};
            dur = '{60, 60, 0};
            cnt = 2;
        end else if (fx == 3) begin
            hp  = '{32, 48, 64};
            dur = '{150, 150, 300};
            cnt = 3;
        end
        idx = n - 1;
        for (int k = 0; k < cnt; k++) begin
            if (idx < dur[k]) begin
                return (((idx / hp[k]) % 2) == 0) ? 16'sd8192 : -16'sd8192;
            end
            idx -= dur[k];
        end
        return 16'sd0;
    endfunction

    // Strobe sample_en after gap idle clocks; returns on the negedge after the strobe edge.
    task automatic strobe(input int gap);
        repeat (gap) @(negedge clk);
        sfx_bus.sample_en = 1'b1;
        @(negedge clk);
        sfx_bus.sample_en = 1'b0;
    endtask

    task automatic pulse(input int fx);
        @(negedge clk);
        sfx_bus.trig_jump  = (fx == 1);
        sfx_bus.trig_score = (fx == 2);
        sfx_bus.trig_over  = (fx == 3);
        @(negedge clk);
        sfx_bus.trig_jump  = 1'b0;
        sfx_bus.trig_score = 1'b0;
        sfx_bus.trig_over  = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (sfx_bus.audio_data !== 16'sd0 || sfx_bus.busy !== 1'b0 || sfx_bus.sfx_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_state audio=%0d busy=%b id=%0d expected 0/0/0",
                     sfx_bus.audio_data, sfx_bus.busy, sfx_bus.sfx_id);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            strobe(3);
            checks++;
            if (sfx_bus.audio_data !== 16'sd0 || sfx_bus.busy !== 1'b0 || sfx_bus.sfx_id !== 2'd0) begin
                failures++;
                $display("FAIL idle n=%0d audio=%0d busy=%b id=%0d expected 0/0/0",
                         n, sfx_bus.audio_data, sfx_bus.busy, sfx_bus.sfx_id);
            end
        end
    endtask

    task automatic test_jump;
        pulse(1);
        checks++;
        if (sfx_bus.busy !== 1'b1 || sfx_bus.sfx_id !== 2'd1 || sfx_bus.audio_data !== 16'sd0) begin
            failures++;
            $display("FAIL jump_accept busy=%b id=%0d audio=%0d expected 1/1/0",
                     sfx_bus.busy, sfx_bus.sfx_id, sfx_bus.audio_data);
        end
        for (int n = 1; n <= 101; n++) begin
            strobe(3);
            checks++;
            if (sfx_bus.audio_data !== exp_wave(1, n) || sfx_bus.busy !== (n < 100)
                || sfx_bus.sfx_id !== ((n < 100) ? 2'd1 : 2'd0)) begin
                failures++;
                $display("FAIL jump n=%0d audio=%0d exp=%0d busy=%b id=%0d",
                         n, sfx_bus.audio_data, exp_wave(1, n), sfx_bus.busy, sfx_bus.sfx_id);
            end
        end
    endtask

    task automatic test_score;
        pulse(2);
        for (int n = 1; n <= 121; n++) begin
            strobe(3);
            checks++;
            if (sfx_bus.audio_data !== exp_wave(2, n) || sfx_bus.busy !== (n < 120)
                || sfx_bus.sfx_id !== ((n < 120) ? 2'd2 : 2'd0)) begin
                failures++;
                $display("FAIL score n=%0d audio=%0d exp=%0d busy=%b id=%0d",
                         n, sfx_bus.audio_data, exp_wave(2, n), sfx_bus.busy, sfx_bus.sfx_id);
            end
        end
    endtask

    task automatic test_priority_drop;
        pulse(2);
        for (int n = 1; n <= 121; n++) begin
            strobe(3);
            checks++;
            if (sfx_bus.audio_data !== exp_wave(2, n) || sfx_bus.busy !== (n < 120)
                || sfx_bus.sfx_id !== ((n < 120) ? 2'd2 : 2'd0)) begin
                failures++;
                $display("FAIL drop n=%0d audio=%0d exp=%0d busy=%b id=%0d",
                         n, sfx_bus.audio_data, exp_wave(2, n), sfx_bus.busy, sfx_bus.sfx_id);
            end
            if (n == 30) begin
                pulse(1);
                checks++;
                if (sfx_bus.sfx_id !== 2'd2) begin
                    failures++;
                    $display("FAIL drop_id id=%0d expected 2", sfx_bus.sfx_id);
                end
            end
        end
    endtask

    task automatic test_preempt;
        pulse(1);
        for (int n = 1; n <= 10; n++) begin
            strobe(3);
            checks++;
            if (sfx_bus.audio_data !== exp_wave(1, n)) begin
                failures++;
                $display("FAIL preempt_jump n=%0d audio=%0d exp=%0d",
                         n, sfx_bus.audio_data, exp_wave(1, n));
            end
        end
        pulse(3);
        checks++;
        if (sfx_bus.sfx_id !== 2'd3 || sfx_bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL preempt_id id=%0d busy=%b expected 3/1", sfx_bus.sfx_id, sfx_bus.busy);
        end
        for (int n = 1; n <= 601; n++) begin
            strobe(3);
            checks++;
            if (sfx_bus.audio_data !== exp_wave(3, n) || sfx_bus.busy !== (n < 600)
                || sfx_bus.sfx_id !== ((n < 600) ? 2'd3 : 2'd0)) begin
                failures++;
                $display("FAIL preempt_over n=%0d audio=%0d exp=%0d busy=%b id=%0d",
                         n, sfx_bus.audio_data, exp_wave(3, n), sfx_bus.busy, sfx_bus.sfx_id);
            end
        end
    endtask

    task automatic test_mute;
        logic signed [15:0] e_a;
        pulse(3);
        for (int n = 1; n <= 601; n++) begin
            if (n == 100) sfx_bus.mute = 1'b1;
            if (n == 201) sfx_bus.mute = 1'b0;
            strobe(3);
            e_a = (n >= 100 && n <= 200) ? 16'sd0 : exp_wave(3, n);
            checks++;
            if (sfx_bus.audio_data !== e_a || sfx_bus.busy !== (n < 600)
                || sfx_bus.sfx_id !== ((n < 600) ? 2'd3 : 2'd0)) begin
                failures++;
                $display("FAIL mute n=%0d audio=%0d exp=%0d busy=%b id=%0d",
                         n, sfx_bus.audio_data, e_a, sfx_bus.busy, sfx_bus.sfx_id);
            end
            if (n == 201) begin
                checks++;
                if (sfx_bus.audio_data !== -16'sd8192) begin
                    failures++;
                    $display("FAIL mute_resume audio=%0d expected -8192", sfx_bus.audio_data);
                end
            end
        end
    endtask

    task automatic test_same_cycle;
        pulse(2);
        for (int n = 1; n <= 19; n++) begin
            strobe(3);
            checks++;
            if (sfx_bus.audio_data !== exp_wave(2, n)) begin
                failures++;
                $display("FAIL same_score n=%0d audio=%0d exp=%0d",
                         n, sfx_bus.audio_data, exp_wave(2, n));
            end
        end
        repeat (3) @(negedge clk);
        sfx_bus.sample_en = 1'b1;
        sfx_bus.trig_over = 1'b1;
        @(negedge clk);
        sfx_bus.sample_en = 1'b0;
        sfx_bus.trig_over = 1'b0;
        checks++;
        if (sfx_bus.audio_data !== -16'sd8192 || sfx_bus.sfx_id !== 2'd3) begin
            failures++;
            $display("FAIL same_cycle_hold audio=%0d id=%0d expected -8192/3",
                     sfx_bus.audio_data, sfx_bus.sfx_id);
        end
        for (int n = 1; n <= 601; n++) begin
            strobe(3);
            checks++;
            if (sfx_bus.audio_data !== exp_wave(3, n) || sfx_bus.busy !== (n < 600)) begin
                failures++;
                $display("FAIL same_over n=%0d audio=%0d exp=%0d busy=%b",
                         n, sfx_bus.audio_data, exp_wave(3, n), sfx_bus.busy);
            end
        end
    endtask

    task automatic test_back_to_back;
        pulse(1);
        for (int n = 1; n <= 40; n++) begin
            strobe(0);
            checks++;
            if (sfx_bus.audio_data !== exp_wave(1, n)) begin
                failures++;
                $display("FAIL b2b n=%0d audio=%0d exp=%0d", n, sfx_bus.audio_data, exp_wave(1, n));
            end
        end
        pulse(1);
        for (int n = 1; n <= 101; n++) begin
            strobe(0);
            checks++;
            if (sfx_bus.audio_data !== exp_wave(1, n) || sfx_bus.busy !== (n < 100)) begin
                failures++;
                $display("FAIL restart n=%0d audio=%0d exp=%0d busy=%b",
                         n, sfx_bus.audio_data, exp_wave(1, n), sfx_bus.busy);
            end
        end
    endtask

    task automatic test_reset_mid;
        pulse(1);
        for (int n = 1; n <= 50; n++) begin
            strobe(3);
        end
        checks++;
        if (sfx_bus.audio_data !== exp_wave(1, 50)) begin
            failures++;
            $display("FAIL reset_mid_pre audio=%0d exp=%0d", sfx_bus.audio_data, exp_wave(1, 50));
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (sfx_bus.audio_data !== 16'sd0 || sfx_bus.busy !== 1'b0 || sfx_bus.sfx_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid audio=%0d busy=%b id=%0d expected 0/0/0",
                     sfx_bus.audio_data, sfx_bus.busy, sfx_bus.sfx_id);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            strobe(3);
            checks++;
            if (sfx_bus.audio_data !== 16'sd0 || sfx_bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_after n=%0d audio=%0d busy=%b expected 0/0",
                         n, sfx_bus.audio_data, sfx_bus.busy);
            end
        end
    endtask

    initial begin
        sfx_bus.sample_en  = 1'b0;
        sfx_bus.trig_jump  = 1'b0;
        sfx_bus.trig_score = 1'b0;
        sfx_bus.trig_over  = 1'b0;
        sfx_bus.mute       = 1'b0;
        test_reset();
        test_jump();
        test_score();
        test_priority_drop();
        test_preempt();
        test_mute();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dino_sfx_gen.md
# dino_sfx_gen

Sound-effect generator for the Dino Run audio path. It converts one-cycle game-event pulses (jump, score milestone, game over) into a signed 16-bit square-wave sample stream. The stream sits directly upstream of the I2S/codec output stage and drives its `audio_data` input. Each effect is a short fixed note sequence, one sample per `sample_en` strobe, with a fixed priority and preemption scheme between effects.

## Interface
Parameters:
- `AMPLITUDE`, default 16'sd8192: positive peak value; the negative half-cycle is `-AMPLITUDE`.
- `MS_SAMPLES`, default 48: samples per millisecond (48 kHz). Benches set it to 1 to shorten runs.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sample_en`  in  1  one-`clk` strobe, one per output sample period.
- `trig_jump`  in  1  one-cycle pulse; request the jump effect.
- `trig_score`  in  1  one-cycle pulse; request the score effect.
- `trig_over`  in  1  one-cycle pulse; request the game-over effect.
- `mute`  in  1  level; forces emitted samples to 0 while playback continues.
- `audio_data`  out  16 signed  registered sample to the codec stage.
- `busy`  out  1  high while an effect is playing.
- `sfx_id`  out  2  effect currently playing: 0 = none, 1 = jump, 2 = score, 3 = game over.

## Operation
- Effect tables. HP is the half-period in samples; duration is in ms × `MS_SAMPLES`.
  - Jump: one note, HP 24, 100 ms.
  - Score: HP 18 for 60 ms, then HP 12 for 60 ms.
  - Game over: HP 32 for 150 ms, then HP 48 for 150 ms, then HP 64 for 300 ms.
- States:
  - IDLE: `busy` = 0, `sfx_id` = 0.
  - PLAY: `busy` = 1, `sfx_id` holds the effect.
- Registers:
  - note index: 0..2.
  - `half_cnt`: 7 bits.
  - `dur_cnt`: 16 bits minimum; it must hold 300 × `MS_SAMPLES` − 1.
  - `phase`: 1 bit; 1 = positive.
- Priority is game over > score > jump.
  - When several triggers are high in the same cycle, only the highest is taken.
  - A trigger is accepted in IDLE, or in PLAY when its priority is ≥ that of the current effect.
  - A trigger with lower priority than the current effect is dropped; nothing is queued.
- Accepting a trigger:
  - Enter PLAY and set `sfx_id`.
  - Set note = 0, `phase` = 1, `half_cnt` = 0, `dur_cnt` = 0.
  - An accepted trigger of the same effect restarts it from note 0.
- On each `sample_en` in PLAY, when no trigger is accepted that cycle:
  - `audio_data` ← `mute` ? 0 : (`phase` ? `AMPLITUDE` : −`AMPLITUDE`).
  - If `half_cnt` == HP−1: toggle `phase` and set `half_cnt` = 0. Otherwise increment `half_cnt`.
  - If `dur_cnt` == DUR−1 and a further note exists: advance the note; set `half_cnt` = 0, `dur_cnt` = 0, `phase` = 1.
  - If `dur_cnt` == DUR−1 on the last note: go to IDLE.
  - Otherwise increment `dur_cnt`.
- On each `sample_en` in IDLE: `audio_data` ← 0.
- `mute` does not stall the counters, `busy` or `sfx_id`; it only zeroes samples.

## Timing
- Reset (asynchronous): state IDLE, `audio_data` = 0, `busy` = 0, `sfx_id` = 0, all counters = 0, `phase` = 1.
- Trigger acceptance:
  - A trigger accepted at clk edge k gives `busy`/`sfx_id` valid after edge k.
  - `audio_data` keeps its value until the first `sample_en` after k. That sample is +`AMPLITUDE` (unmuted).
- Trigger and `sample_en` in the same cycle:
  - The trigger load wins.
  - `audio_data` is not updated that cycle.
  - The first waveform sample comes on the next `sample_en`.
- Outputs change only on clk edges. `audio_data` changes only on `sample_en` cycles.
- Exact length of an effect: the sum of its note durations in emitted samples.
- End of an effect:
  - `busy` falls on the same edge that emits the final sample.
  - The next `sample_en` emits 0.
- Preemption:
  - Occurs mid-note or mid-half-period with no extra sample.
  - The next `sample_en` emits the first sample of the new effect.
- A reset asserted mid-effect aborts playback immediately; no residual samples are emitted.
- `sample_en` arriving on consecutive clk cycles is legal; each strobe is one sample.

## Test plan
All scenarios use `MS_SAMPLES` = 1, `AMPLITUDE` = 8192, and `sample_en` every 4 clk.
- Reset then idle 50 strobes → `audio_data` = 0, `busy` = 0, `sfx_id` = 0 throughout.
- Pulse `trig_jump` → exactly 100 samples: 24 × +8192, 24 × −8192, repeating, ending on +8192 × 4 (samples 97–100). `busy` falls with sample 100; sample 101 = 0.
- Pulse `trig_score` → 60 samples at HP 18, then 60 samples at HP 12 starting +8192 at sample 61; total 120 samples; `sfx_id` = 2 throughout.
- Start `trig_score`, pulse `trig_jump` at sample 30 → jump ignored, score completes 120 samples. Then start `trig_jump` and pulse `trig_over` at sample 10 → sample 11 = +8192, `sfx_id` = 3, 600 game-over samples follow.
- Play game over with `mute` high during samples 100–200 → those samples = 0, sample 201 follows the HP 48 pattern, total length remains 600.
- Assert `reset` at sample 50 of jump → `audio_data` = 0 and `busy` = 0 asynchronously; no further nonzero samples without a new trigger.
